// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI frontend and register blocks
package spi_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    OPCODE,
    OPERAND
  } state_t;

  // Opcodes decoded by the downstream per-register blocks
  localparam logic [BYTE_WIDTH-1:0] OP_WRITE  = 8'h02;
  localparam logic [BYTE_WIDTH-1:0] OP_READ   = 8'h03;
  localparam logic [BYTE_WIDTH-1:0] OP_STATUS = 8'h05;

  // Increment that sticks at all-ones
  function automatic logic [BYTE_WIDTH-1:0] sat_inc(input logic [BYTE_WIDTH-1:0] v);
    return (v == {BYTE_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spi_peripheral_frontend_if.sv
// rtl/spi_peripheral_frontend_if.sv - byte-level bus between the SPI frontend and the register blocks
interface spi_peripheral_frontend_if;
  import spi_pkg::*;

  logic [BYTE_WIDTH-1:0] opcode;
  logic                  opcode_valid;
  logic [BYTE_WIDTH-1:0] operand;
  logic                  operand_valid;
  logic [BYTE_WIDTH-1:0] operand_count;
  logic [BYTE_WIDTH-1:0] response;
  logic                  response_valid;

  modport master (
    output opcode, opcode_valid, operand, operand_valid, operand_count,
    input  response, response_valid
  );

  modport slave (
    input  opcode, opcode_valid, operand, operand_valid, operand_count,
    output response, response_valid
  );

endinterface

// File: rtl/spi_input_synchronizer.sv
// rtl/spi_input_synchronizer.sv - multi-stage synchronizer with rise/fall pulse detection
module spi_input_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Shift the pin through the synchronizer and keep one extra sample for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_peripheral_frontend.sv
// rtl/spi_peripheral_frontend.sv - SPI mode-0 peripheral frontend; optional idle timeout under SPI_TIMEOUT_EN
module spi_peripheral_frontend
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        spi_select_in,
  input  logic                        spi_clock_in,
  input  logic                        spi_data_in,
  output logic                        spi_data_out,
  spi_peripheral_frontend_if.master   reg_bus
);

  logic sel_level, sel_rise, sel_fall;
  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic timeout_hit;

  spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_select (
    .clock(clock), .reset_n(reset_n), .async_in(spi_select_in),
    .level(sel_level), .rise(sel_rise), .fall(sel_fall)
  );

  spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clock(clock), .reset_n(reset_n), .async_in(spi_clock_in),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clock(clock), .reset_n(reset_n), .async_in(spi_data_in),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_level, copi_rise, copi_fall};

  // SCLK edges only count while the peripheral is selected
  logic bit_rise, bit_fall;
  assign bit_rise = sclk_rise & ~sel_level;
  assign bit_fall = sclk_fall & ~sel_level;

`ifdef SPI_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] idle_count;

  // Count clocks since the last bus activity, saturating
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_count <= '0;
    end else if (sclk_rise | sclk_fall | sel_rise | sel_fall) begin
      idle_count <= '0;
    end else if (idle_count != 16'hFFFF) begin
      idle_count <= idle_count + 16'd1;
    end
  end

  assign timeout_hit = (idle_count >= TIMEOUT_LIMIT);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
`endif

  state_t                state;
  logic [2:0]            bit_count;
  logic [BYTE_WIDTH-1:0] rx_shift;
  logic [BYTE_WIDTH-1:0] tx_shift;
  logic                  tx_skip;
  logic                  byte_done;
  logic                  done_is_opcode;
  logic [BYTE_WIDTH-1:0] opcode_q;
  logic                  opcode_valid_q;
  logic [BYTE_WIDTH-1:0] operand_q;
  logic                  operand_valid_q;
  logic [BYTE_WIDTH-1:0] operand_count_q;
  logic                  data_out_q;

  logic [BYTE_WIDTH-1:0] tx_load;
  assign tx_load = reg_bus.response_valid ? reg_bus.response : '0;

  // Transaction FSM: bit shifting, byte completion and CIPO serialization
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      bit_count       <= '0;
      rx_shift        <= '0;
      tx_shift        <= '0;
      tx_skip         <= 1'b0;
      byte_done       <= 1'b0;
      done_is_opcode  <= 1'b0;
      opcode_q        <= '0;
      opcode_valid_q  <= 1'b0;
      operand_q       <= '0;
      operand_valid_q <= 1'b0;
      operand_count_q <= '0;
      data_out_q      <= 1'b0;
    end else begin
      byte_done       <= 1'b0;
      operand_valid_q <= 1'b0;
      if (operand_valid_q) operand_count_q <= sat_inc(operand_count_q);

      if (sel_rise || (timeout_hit && state != IDLE)) begin
        state          <= IDLE;
        bit_count      <= '0;
        opcode_valid_q <= 1'b0;
        tx_shift       <= '0;
        tx_skip        <= 1'b0;
        data_out_q     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sel_fall) begin
              state     <= OPCODE;
              bit_count <= '0;
            end
          end
          OPCODE: begin
            if (bit_rise) begin
              rx_shift  <= {rx_shift[BYTE_WIDTH-2:0], copi_level};
              bit_count <= bit_count + 3'd1;
              if (bit_count == 3'd7) begin
                state          <= OPERAND;
                byte_done      <= 1'b1;
                done_is_opcode <= 1'b1;
                tx_shift       <= tx_load;
                data_out_q     <= tx_load[BYTE_WIDTH-1];
                tx_skip        <= 1'b1;
              end
            end
          end
          OPERAND: begin
            if (bit_rise) begin
              rx_shift  <= {rx_shift[BYTE_WIDTH-2:0], copi_level};
              bit_count <= bit_count + 3'd1;
              if (bit_count == 3'd7) begin
                byte_done      <= 1'b1;
                done_is_opcode <= 1'b0;
                tx_shift       <= tx_load;
                data_out_q     <= tx_load[BYTE_WIDTH-1];
                tx_skip        <= 1'b1;
              end
            end else if (bit_fall) begin
              if (tx_skip) begin
                tx_skip <= 1'b0;
              end else begin
                tx_shift   <= {tx_shift[BYTE_WIDTH-2:0], 1'b0};
                data_out_q <= tx_shift[BYTE_WIDTH-2];
              end
            end
          end
          default: state <= IDLE;
        endcase

        if (byte_done) begin
          if (done_is_opcode) begin
            opcode_q        <= rx_shift;
            opcode_valid_q  <= 1'b1;
            operand_count_q <= '0;
          end else begin
            operand_q       <= rx_shift;
            operand_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign spi_data_out          = data_out_q;
  assign reg_bus.opcode        = opcode_q;
  assign reg_bus.opcode_valid  = opcode_valid_q;
  assign reg_bus.operand       = operand_q;
  assign reg_bus.operand_valid = operand_valid_q;
  assign reg_bus.operand_count = operand_count_q;

endmodule

// File: tb/tb_spi_peripheral_frontend.sv
// tb/tb_spi_peripheral_frontend.sv - scoreboard bench for spi_peripheral_frontend; honours SPI_TIMEOUT_EN
module tb_spi_peripheral_frontend;

  localparam int SYNC = 2;
`ifdef SPI_TIMEOUT_EN
  localparam int TO_CYCLES = 100;
`else
  localparam int TO_CYCLES = 65535;
`endif

  typedef struct {
    logic [7:0] data;
    logic [7:0] count;
    int         cycle;
  } exp_t;

  logic clock;
  logic reset_n;
  logic spi_select;
  logic spi_clock;
  logic spi_copi;
  logic spi_cipo;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic opv_prev = 1'b0;

  logic [7:0] exp_op_q[$];
  exp_t       exp_operand_q[$];

  spi_peripheral_frontend_if bus ();

  spi_peripheral_frontend #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .spi_select_in(spi_select),
    .spi_clock_in(spi_clock),
    .spi_data_in(spi_copi),
    .spi_data_out(spi_cipo),
    .reg_bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycle = cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every opcode_valid rise and operand_valid pulse is matched to the model
  always @(negedge clock) begin
    logic [7:0] eo;
    exp_t ex;
    if (reset_n) begin
      if (bus.opcode_valid && !opv_prev) begin
        if (exp_op_q.size() == 0) check("opcode_valid_rise_unexpected", bus.opcode_valid, 0);
        else begin
          eo = exp_op_q.pop_front();
          check("opcode", bus.opcode, eo);
        end
      end
      if (bus.operand_valid) begin
        if (exp_operand_q.size() == 0) check("operand_valid_unexpected", bus.operand_valid, 0);
        else begin
          ex = exp_operand_q.pop_front();
          check("operand", bus.operand, ex.data);
          check("operand_count", bus.operand_count, ex.count);
          check("operand_latency", cycle, ex.cycle);
        end
      end
    end
    opv_prev = bus.opcode_valid;
  end

  // Master side: drive bits hi..lo of b MSB-first at SCLK = clock/8; kind 1 = opcode, 2 = operand idx
  task automatic send_bits(input logic [7:0] b, input int hi, input int lo, input int kind,
                           input int idx, input bit chk, input logic [7:0] exp_miso);
    logic [7:0] got;
    exp_t e;
    got = '0;
    for (int i = hi; i >= lo; i--) begin
      spi_clock = 1'b0;
      spi_copi  = b[i];
      repeat (4) @(negedge clock);
      got[i]    = spi_cipo;
      spi_clock = 1'b1;
      if (i == 0) begin
        if (kind == 1) exp_op_q.push_back(b);
        else if (kind == 2) begin
          e.data  = b;
          e.count = (idx > 255) ? 8'd255 : 8'(idx);
          e.cycle = cycle + SYNC + 2;
          exp_operand_q.push_back(e);
        end
      end
      repeat (4) @(negedge clock);
    end
    if (chk) check("cipo_byte", got, exp_miso);
  endtask

  task automatic begin_txn(input logic [7:0] op, input logic [7:0] resp, input bit rv);
    bus.response       = resp;
    bus.response_valid = rv;
    spi_select = 1'b0;
    repeat (4) @(negedge clock);
    send_bits(op, 7, 0, 1, 0, 1, 8'h00);
  endtask

  task automatic end_txn();
    spi_clock = 1'b0;
    repeat (4) @(negedge clock);
    spi_select = 1'b1;
    repeat (8) @(negedge clock);
    check("opcode_valid_after_deselect", bus.opcode_valid, 0);
  endtask

  task automatic full_txn(input logic [7:0] op, input int n, input logic [7:0] resp, input bit rv);
    logic [7:0] b;
    begin_txn(op, resp, rv);
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom);
      send_bits(b, 7, 0, 2, k, 1, rv ? resp : 8'h00);
    end
    end_txn();
  endtask

  initial begin
    logic [7:0] op;
    spi_select = 1'b1;
    spi_clock  = 1'b0;
    spi_copi   = 1'b0;
    bus.response       = '0;
    bus.response_valid = 1'b0;
    reset_n = 1'b0;
    repeat (5) @(negedge clock);
    check("reset_opcode", bus.opcode, 0);
    check("reset_opcode_valid", bus.opcode_valid, 0);
    check("reset_operand", bus.operand, 0);
    check("reset_operand_valid", bus.operand_valid, 0);
    check("reset_operand_count", bus.operand_count, 0);
    check("reset_cipo", spi_cipo, 0);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);

    // Reference transaction, response invalid then valid
    begin_txn(8'hB5, 8'h54, 1'b0);
    send_bits(8'h3C, 7, 0, 2, 0, 1, 8'h00);
    send_bits(8'hA1, 7, 0, 2, 1, 1, 8'h00);
    end_txn();
    begin_txn(8'hB5, 8'h54, 1'b1);
    send_bits(8'h3C, 7, 0, 2, 0, 1, 8'h54);
    send_bits(8'hA1, 7, 0, 2, 1, 1, 8'h54);
    end_txn();

    // Randomized transactions
    for (int t = 0; t < 6; t++)
      full_txn(8'($urandom), $urandom_range(1, 4), 8'($urandom), 1'($urandom_range(0, 1)));

    // Deselect after 5 operand bits, then a clean transaction
    begin_txn(8'h5A, 8'h00, 1'b0);
    send_bits(8'hFF, 7, 3, 0, 0, 0, 8'h00);
    end_txn();
    full_txn(8'hC7, 1, 8'h99, 1'b1);

    // Deselect coinciding with the 8th rising edge of an operand byte
    begin_txn(8'h11, 8'h00, 1'b0);
    send_bits(8'h6E, 7, 1, 0, 0, 0, 8'h00);
    spi_clock = 1'b0;
    spi_copi  = 1'b1;
    repeat (4) @(negedge clock);
    spi_clock  = 1'b1;
    spi_select = 1'b1;
    repeat (12) @(negedge clock);
    check("opcode_valid_after_coincident_deselect", bus.opcode_valid, 0);
    spi_clock = 1'b0;
    repeat (8) @(negedge clock);
    full_txn(8'h3D, 2, 8'h0F, 1'b1);

    // 300 operand bytes: count saturates at 255
    full_txn(8'hE2, 300, 8'hC3, 1'b1);

    // Reset during opcode bit 3; no capture until select toggles
    spi_select = 1'b0;
    repeat (4) @(negedge clock);
    send_bits(8'hF0, 7, 5, 0, 0, 0, 8'h00);
    reset_n = 1'b0;
    #1;
    check("midbyte_reset_opcode", bus.opcode, 0);
    check("midbyte_reset_opcode_valid", bus.opcode_valid, 0);
    check("midbyte_reset_operand", bus.operand, 0);
    check("midbyte_reset_operand_count", bus.operand_count, 0);
    check("midbyte_reset_cipo", spi_cipo, 0);
    @(negedge clock);
    reset_n = 1'b1;
    send_bits(8'hA5, 7, 0, 0, 0, 0, 8'h00);
    send_bits(8'h42, 7, 0, 0, 0, 0, 8'h00);
    repeat (8) @(negedge clock);
    check("no_capture_without_fresh_select", bus.opcode_valid, 0);
    spi_clock = 1'b0;
    repeat (4) @(negedge clock);
    spi_select = 1'b1;
    repeat (8) @(negedge clock);
    full_txn(8'h81, 2, 8'h7E, 1'b1);

    // SCLK stall mid operand byte
    begin_txn(8'h2B, 8'h00, 1'b0);
    send_bits(8'hD6, 7, 5, 0, 0, 0, 8'h00);
    repeat (150) @(negedge clock);
`ifdef SPI_TIMEOUT_EN
    check("stall_timeout_opcode_valid", bus.opcode_valid, 0);
    send_bits(8'hD6, 4, 0, 0, 0, 0, 8'h00);
`else
    check("stall_hold_opcode_valid", bus.opcode_valid, 1);
    send_bits(8'hD6, 4, 0, 2, 0, 0, 8'h00);
`endif
    end_txn();
    full_txn(8'h96, 1, 8'h33, 1'b1);

    repeat (20) @(negedge clock);
    check("opcode_queue_drained", exp_op_q.size(), 0);
    check("operand_queue_drained", exp_operand_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/spi_peripheral_frontend.md
Name: spi_peripheral_frontend

Overview:
- SPI mode-0 peripheral frontend. Oversamples the asynchronous SPI pins in the system clock domain, deserializes the opcode byte and the operand bytes that follow it, and serializes response bytes onto CIPO.
- Sits directly upstream of the per-register SPI blocks.
  - It supplies their enable (opcode match), byte strobe, operand/valid and byte index.
  - It consumes their response byte/valid.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each SPI input; legal range 2..3.
- TIMEOUT_CYCLES, 65535: idle system clocks before a forced return to IDLE. Used only with SPI_TIMEOUT_EN.

Ports:
- clock  input  1  system clock; must be at least 4x the SCLK frequency.
- reset_n  input  1  asynchronous active-low reset.
- spi_select_in  input  1  chip select, active low, asynchronous.
- spi_clock_in  input  1  SCLK, asynchronous.
- spi_data_in  input  1  COPI, asynchronous.
- spi_data_out  output  1  CIPO, registered.
- opcode  output  8  first byte of the current transaction.
- opcode_valid  output  1  high from opcode capture until select is released.
- operand  output  8  most recent complete operand byte.
- operand_valid  output  1  one-clock pulse per complete operand byte.
- operand_count  output  8  index of the byte in `operand`, starting at 0; saturates at 255.
- response  input  8  byte to shift out next, supplied by the register block.
- response_valid  input  1  qualifies `response`; when low, 0x00 is shifted instead.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Bit counter 0.
- Input conditioning:
  - Each pin passes through a SYNC_STAGES synchronizer.
  - Rising and falling SCLK edges are detected from the last two synchronized samples. Each edge produces a one-clock internal pulse.
- Bit protocol:
  - MSB first.
  - COPI is sampled on SCLK rising edges.
  - CIPO changes on SCLK falling edges.
- State machine:
  - IDLE -> OPCODE when synchronized select falls; bit counter is cleared.
  - OPCODE: shift 8 bits. On the 8th rising edge:
    - latch `opcode`;
    - set `opcode_valid` in the next clock;
    - go to OPERAND;
    - clear `operand_count` to 0.
  - OPERAND: shift 8 bits per byte. On the 8th rising edge, in the next clock:
    - update `operand`;
    - pulse `operand_valid`;
    - increment `operand_count` after the pulse, saturating at 255.
  - Any state -> IDLE when synchronized select rises:
    - partial byte discarded;
    - no `operand_valid` pulse;
    - `opcode_valid` cleared;
    - `opcode` and `operand` hold their last value.
- Latency: last SCLK rising edge at the pin -> `operand_valid` is SYNC_STAGES+2 clocks.
- CIPO:
  - Drives 0 throughout OPCODE.
  - On entry to OPERAND, and at each byte boundary, the TX shift register loads `response`, or 0x00 when `response_valid` is low.
  - The MSB is driven immediately, before the next rising edge.
  - Each subsequent falling edge shifts left by one.
  - The falling edge that follows the 8th rising edge of a byte does not shift; the load takes its place.
  - `spi_data_out` returns to 0 in IDLE.
- Boundary conditions:
  - A rising and falling SCLK edge never occur in the same clock; this is guaranteed by the clock ratio.
  - If select rises in the same clock as the 8th rising edge, the byte is discarded: deselect wins.
  - SCLK edges while select is high are ignored.
  - Glitches shorter than one clock are not guaranteed to be filtered.
- reset_n asserted mid-byte: immediate return to reset values. After release, the block waits in IDLE for a fresh select falling edge, even if select is already low.

Optional Feature:
- Macro: SPI_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter clears on every SCLK edge and every select change.
  - Outside IDLE, reaching TIMEOUT_CYCLES forces IDLE: partial byte discarded, `opcode_valid` cleared.
  - The block then remains in IDLE until select is released and reasserted.
- Undefined: no counter is built; a stalled master holds the state indefinitely.

Decomposition:
- Package spi_pkg:
  - state enum {IDLE, OPCODE, OPERAND};
  - opcode localparams shared with the register blocks;
  - byte width constant 8.
- Sub-module spi_input_synchronizer:
  - parameterised SYNC_STAGES;
  - one instance per pin;
  - provides the synchronized level plus rise/fall pulses.
- Shift registers, counters and FSM stay in this top module.

Test Plan:
- Select low, send 0xB5 then 0x3C, 0xA1 at SCLK = clock/8, select high:
  - `opcode`=0xB5 with `opcode_valid`=1 after byte 1;
  - `operand_valid` pulses twice, `operand` 0x3C with count 0, then 0xA1 with count 1;
  - `opcode_valid`=0 after deselect.
- Same transaction with `response`=0x54 and `response_valid`=1 during the operand phase: CIPO carries 0x00 during the opcode byte, then 0x54 MSB-first. With `response_valid`=0, CIPO carries 0x00.
- Select released after 5 bits of an operand byte: no `operand_valid` pulse, FSM in IDLE. The next transaction decodes its opcode correctly.
- 300 operand bytes in one transaction: `operand_count` reaches 255 and holds; `operand_valid` continues to pulse every byte.
- reset_n asserted during bit 3 of the opcode: all outputs 0 immediately. No capture occurs until select toggles high then low.
- With SPI_TIMEOUT_EN and TIMEOUT_CYCLES=100: hold SCLK static for 100 clocks mid-byte -> IDLE, `opcode_valid`=0. Without the macro, the same stall keeps the state, and the byte completes when SCLK resumes.
